// File: rtl/mips_pkg.sv
// Shared MIPS core types used by the multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

  localparam int MD_ITERS = 32;

endpackage

// File: rtl/md_sign_adjust.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module md_sign_adjust #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t   state;
  md_op_t      op_q;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [31:0] orig_a;
  logic        neg_res;
  logic        neg_rem;
  logic        dbz_q;

  logic        op_signed;
  logic        op_is_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        is_div_q;
  logic [32:0] mul_sum;
  logic [32:0] rem_trial;
  logic [31:0] rem_diff;
  logic        rem_ge;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign op_signed = ~op[0];
  assign op_is_div = op[1];
  assign sign_a    = op_signed & src_a[31];
  assign sign_b    = op_signed & src_b[31];
  assign is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);

  md_sign_adjust #(.W(32)) u_abs_a (.neg(sign_a), .value(src_a), .result(a_abs));
  md_sign_adjust #(.W(32)) u_abs_b (.neg(sign_b), .value(src_b), .result(b_abs));

  // Shift-add multiply: upper half accumulates, carry shifts into bit 63.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

  // Restoring divide: the remainder never exceeds the divisor, so a 32-bit difference suffices.
  assign rem_trial = {acc[63:32], acc[31]};
  assign rem_ge    = rem_trial >= {1'b0, opnd};
  assign rem_diff  = rem_trial[31:0] - opnd;

  md_sign_adjust #(.W(64)) u_fix_prod (.neg(neg_res), .value(acc),         .result(prod_fixed));
  md_sign_adjust #(.W(32)) u_fix_quo  (.neg(neg_res), .value(acc[31:0]),   .result(quo_fixed));
  md_sign_adjust #(.W(32)) u_fix_rem  (.neg(neg_rem), .value(acc[63:32]),  .result(rem_fixed));

  assign busy        = (state == CALC) || (state == FIX);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) && dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= MD_MULT;
      cnt     <= 6'd0;
      acc     <= 64'd0;
      opnd    <= 32'd0;
      orig_a  <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state   <= CALC;
            op_q    <= md_op_t'(op);
            cnt     <= 6'd0;
            orig_a  <= src_a;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            dbz_q   <= op_is_div && (src_b == 32'd0);
            opnd    <= op_is_div ? b_abs : a_abs;
            acc     <= {32'd0, op_is_div ? a_abs : b_abs};
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (is_div_q)
            acc <= rem_ge ? {rem_diff, acc[30:0], 1'b1} : {rem_trial[31:0], acc[30:0], 1'b0};
          else
            acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MD_ITERS - 1)) state <= FIX;
        end
        FIX: begin
          // Divide by zero still runs the full iteration count; its result is substituted here.
          if (!is_div_q) begin
            hi <= prod_fixed[63:32];
            lo <= prod_fixed[31:0];
          end else if (dbz_q) begin
            hi <= orig_a;
            lo <= '1;
          end else begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total_checks = 0;
  int passed_checks = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    else
      passed_checks++;
  endtask

  // Architectural result of one operation, straight from signed/unsigned integer arithmetic.
  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z  = 1'b0;
    h  = 32'd0;
    l  = 32'd0;
    case (o)
      2'b00: begin sp = sa * sb; p = sp; h = p[63:32]; l = p[31:0]; end
      2'b01: begin up = ua * ub; p = up; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          p = sq; l = p[31:0];
          p = sr; h = p[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Issue one operation and follow it to done; optionally poke writes and a second start mid-flight.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] eh, el;
    logic        ez;
    int          cycles, busy_cycles;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      if (inject && cycles == 5) begin
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = ~o; src_b = 32'd0;
      end
      if (inject && cycles == 6) begin
        lo_we = 1'b0; hi_we = 1'b0; start = 1'b0;
        checkOutput("lo_write_while_busy", {32'd0, lo}, {32'd0, exp_lo});
        checkOutput("hi_write_while_busy", {32'd0, hi}, {32'd0, exp_hi});
      end
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput($sformatf("latency op%0d", o), 64'(cycles), 64'd33);
    checkOutput($sformatf("busy_cycles op%0d", o), 64'(busy_cycles), 64'd33);
    refModel(o, a, b, eh, el, ez);
    exp_hi = eh;
    exp_lo = el;
    checkOutput($sformatf("hi op%0d a=%h b=%h", o, a, b), {32'd0, hi}, {32'd0, eh});
    checkOutput($sformatf("lo op%0d a=%h b=%h", o, a, b), {32'd0, lo}, {32'd0, el});
    checkOutput($sformatf("div_by_zero op%0d", o), {63'd0, div_by_zero}, {63'd0, ez});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI/MTLO while idle
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    exp_hi = 32'h0000_1234;
    checkOutput("mthi_idle", {32'd0, hi}, 64'h1234);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    exp_lo = 32'h0000_5678;
    checkOutput("mtlo_idle", {32'd0, lo}, 64'h5678);

    // Directed corner cases, issued back to back from DONE
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(2'b11, 32'd7, 32'd2, 1'b0);
    applyStimulus(2'b11, 32'd100, 32'd0, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(2'b10, 32'h1234_5678, 32'd0, 1'b0);
    applyStimulus(2'b10, 32'd1000, 32'd7, 1'b1);

    @(posedge clk); #1;
    checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
    checkOutput("idle_not_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 16));
        2: rb = -32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      applyStimulus(ro, ra, rb, 1'b0);
    end

    // Make HI/LO nonzero, then abort a DIVU with reset mid-iteration
    applyStimulus(2'b11, 32'd1001, 32'd10, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd5000; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b01, 32'd6, 32'd7, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
